spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address field width in bits (8 or 16); MSB is the read flag.
REQ-002 SHALL have parameter DATA_W, default 8, data field width in bits (8 or 16).
REQ-003 SHALL have port clk  input  1  system clock; must be at least 8x the sck frequency.
REQ-004 SHALL have port reset_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port sck  input  1  serial clock from master; idles low.
REQ-006 SHALL have port ss  input  1  slave select from master; active low.
REQ-007 SHALL have port mosi  input  1  master-to-slave data, MSB first.
REQ-008 SHALL have port miso  output  1  slave-to-master data, MSB first.
REQ-009 SHALL have port wr_valid  output  1  one-cycle write strobe.
REQ-010 SHALL have port wr_addr  output  ADDR_W-1  write address, read flag stripped.
REQ-011 SHALL have port wr_data  output  DATA_W  write data.
REQ-012 SHALL have port rd_valid  output  1  one-cycle read request strobe.
REQ-013 SHALL have port rd_addr  output  ADDR_W-1  read address.
REQ-014 SHALL have port rd_data  input  DATA_W  read data; must be valid 2 clk cycles after rd_valid.
REQ-015 SHALL have port busy  output  1  high while a frame is in progress (ss low).

Function
REQ-016 SHALL pass sck, ss and mosi through 2-flop synchronizers, and detect sck rise/fall and ss fall/rise on the synchronized signals.
REQ-017 SHALL implement states IDLE, ADDR, WDATA, RDATA and WAIT_SS.
REQ-018 IDLE SHALL go to ADDR on the ss falling edge, with bit counter = ADDR_W-1.
REQ-019 In ADDR, SHALL shift mosi into the address register on each sck rise; after ADDR_W bits SHALL go to RDATA if the read flag = 1, else to WDATA; bit counter = DATA_W-1 on either transition.
REQ-020 Read request SHALL pulse rd_valid with rd_addr in the cycle after the last address bit is sampled.
REQ-021 Read data SHALL capture rd_data into the TX shift register 2 cycles after rd_valid, drive its MSB on miso, and shift the next bit onto miso after each sck fall.
REQ-022 In WDATA, SHALL shift mosi on each sck rise; after DATA_W bits SHALL pulse wr_valid for one cycle with wr_addr/wr_data, then go to WAIT_SS.
REQ-023 RDATA SHALL go to WAIT_SS after DATA_W sck falls; WAIT_SS SHALL go to IDLE on ss rise.
REQ-024 SHALL abort to IDLE from any state on ss rise, with no wr_valid and no further rd_valid.
REQ-025 SHALL hold miso = 0 except in RDATA.
REQ-026 SHALL ignore sck edges while ss is high, and ignore extra sck edges in WAIT_SS.
REQ-027 Back-to-back frames SHALL be accepted when ss is high for at least 2 clk cycles between them.

Reset
REQ-028 Reset SHALL put the block in IDLE with miso, wr_valid, rd_valid and busy = 0, all registers = 0 and synchronizers loaded to ss = 1, sck = 0, mosi = 0.
REQ-029 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait for a fresh ss fall.

Configuration
REQ-030 With SPI_SLAVE_ERR_EN defined, SHALL add output frame_err (1 bit), pulsed for one cycle on an abort per REQ-024 in ADDR, WDATA or RDATA, and output err_count (8 bits), which saturates at 255.
REQ-031 Without SPI_SLAVE_ERR_EN, those ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Package spi_pkg SHALL hold the state encodings and the width constants and limits ADDR_W and DATA_W.
REQ-033 Sub-module spi_sync SHALL implement the 2-flop synchronizer with a reset-value parameter, instantiated three times.

Verification
REQ-034 Write test: ADDR_W=8, DATA_W=8, send 0x12 then 0xA5 -> one wr_valid, wr_addr=0x12, wr_data=0xA5, no rd_valid.
REQ-035 Read test: ADDR_W=16, DATA_W=16, send 0x8034 with rd_data=0xBEEF -> rd_valid with rd_addr=0x0034; master shifts in 0xBEEF.
REQ-036 Abort test: ss rises after 11 of 16 write bits -> no wr_valid; frame_err pulses and err_count=1 when SPI_SLAVE_ERR_EN is defined.
REQ-037 Back-to-back test: writes 0x01/0x11 then 0x02/0x22 with 2-cycle ss high gap -> two wr_valid pulses in order.
REQ-038 Reset test: reset_n asserted mid-read -> miso=0, state IDLE; next write 0x05/0x5A -> wr_data=0x5A.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared state encoding, width defaults/limits and counter sizing for the SPI slave.
package spi_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int W_MAX      = 16;
    localparam int CNT_W      = $clog2(W_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_WAIT_SS
    } state_t;

    function automatic logic [CNT_W-1:0] last_bit(input int w);
        return CNT_W'(w - 1);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with a configurable reset value.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_ff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_ff <= {2{RST_VAL}};
        else          r_ff <= {r_ff[0], i_d};
    end

    assign o_q = r_ff[1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave turning address/data frames into write strobes and read requests.
// Optional frame_err/err_count outputs are enabled by defining SPI_SLAVE_ERR_EN.
module spi_slave
    import spi_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              wr_valid,
    output logic [ADDR_W-2:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [ADDR_W-2:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy
`ifdef SPI_SLAVE_ERR_EN
    ,
    output logic              frame_err,
    output logic [7:0]        err_count
`endif
);

    logic w_sck, w_ss, w_mosi;

    spi_sync #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .reset_n(reset_n), .i_d(sck),  .o_q(w_sck));
    spi_sync #(.RST_VAL(1'b1)) u_sync_ss   (.clk(clk), .reset_n(reset_n), .i_d(ss),   .o_q(w_ss));
    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .reset_n(reset_n), .i_d(mosi), .o_q(w_mosi));

    logic              r_sck_d, r_ss_d;
    logic [1:0]        r_warm;
    logic              r_armed;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-2:0] r_addr;
    logic [DATA_W-2:0] r_wdata;
    logic [DATA_W-1:0] r_tx;
    logic              r_skip;
    logic [1:0]        r_rd_pipe;

    logic              w_sck_rise, w_sck_fall, w_ss_fall, w_ss_rise, w_abort;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;

    assign w_sck_rise  = w_sck & ~r_sck_d;
    assign w_sck_fall  = ~w_sck & r_sck_d;
    assign w_ss_fall   = ~w_ss & r_ss_d;
    assign w_ss_rise   = w_ss & ~r_ss_d;
    assign w_abort     = w_ss_rise &&
                         (r_state == ST_ADDR || r_state == ST_WDATA || r_state == ST_RDATA);
    assign w_addr_nxt  = {r_addr, w_mosi};
    assign w_wdata_nxt = {r_wdata, w_mosi};

    assign miso = (r_state == ST_RDATA) & r_tx[DATA_W-1];
    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sck_d   <= 1'b0;
            r_ss_d    <= 1'b1;
            r_warm    <= '0;
            r_armed   <= 1'b0;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_tx      <= '0;
            r_skip    <= 1'b0;
            r_rd_pipe <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_valid  <= 1'b0;
            rd_addr   <= '0;
        end else begin
            r_sck_d   <= w_sck;
            r_ss_d    <= w_ss;
            wr_valid  <= 1'b0;
            rd_valid  <= 1'b0;
            r_rd_pipe <= {r_rd_pipe[0], rd_valid};
            // A fall seen straight out of reset reflects the reset value, not the master;
            // only arm once a settled ss-high has been observed.
            r_warm    <= {r_warm[0], 1'b1};
            if (r_warm[1] && w_ss) r_armed <= 1'b1;
            if (r_rd_pipe[1] && r_state == ST_RDATA) r_tx <= rd_data;

            if (w_abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_ss_fall && r_armed) begin
                        r_state <= ST_ADDR;
                        r_cnt   <= last_bit(ADDR_W);
                    end
                    ST_ADDR: if (w_sck_rise) begin
                        r_addr <= w_addr_nxt[ADDR_W-2:0];
                        if (r_cnt == '0) begin
                            r_cnt <= last_bit(DATA_W);
                            if (w_addr_nxt[ADDR_W-1]) begin
                                r_state  <= ST_RDATA;
                                rd_valid <= 1'b1;
                                rd_addr  <= w_addr_nxt[ADDR_W-2:0];
                                r_tx     <= '0;
                                r_skip   <= 1'b1;
                            end else begin
                                r_state <= ST_WDATA;
                            end
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    ST_WDATA: if (w_sck_rise) begin
                        r_wdata <= w_wdata_nxt[DATA_W-2:0];
                        if (r_cnt == '0) begin
                            wr_valid <= 1'b1;
                            wr_addr  <= r_addr;
                            wr_data  <= w_wdata_nxt;
                            r_state  <= ST_WAIT_SS;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    // The first fall here trails the last address bit and must not shift.
                    ST_RDATA: if (w_sck_fall) begin
                        if (r_skip) begin
                            r_skip <= 1'b0;
                        end else begin
                            r_tx <= {r_tx[DATA_W-2:0], 1'b0};
                            if (r_cnt == '0) r_state <= ST_WAIT_SS;
                            else             r_cnt   <= r_cnt - CNT_W'(1);
                        end
                    end
                    ST_WAIT_SS: if (w_ss_rise) r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SPI_SLAVE_ERR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            frame_err <= w_abort;
            if (w_abort && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Randomized bench for spi_slave: an 8/8 and a 16/16 instance share sck/mosi, each with its own ss.
module tb_spi_slave;

    logic clk = 1'b0, reset_n = 1'b0, sck = 1'b0, mosi = 1'b0, ss_a = 1'b1, ss_b = 1'b1;
    always #5 clk = ~clk;

    logic        miso_a, wr_valid_a, rd_valid_a, busy_a;
    logic [6:0]  wr_addr_a, rd_addr_a;
    logic [7:0]  wr_data_a, rd_data_a;
    logic        miso_b, wr_valid_b, rd_valid_b, busy_b;
    logic [14:0] wr_addr_b, rd_addr_b;
    logic [15:0] wr_data_b, rd_data_b;
`ifdef SPI_SLAVE_ERR_EN
    logic        frame_err_a, frame_err_b;
    logic [7:0]  err_count_a, err_count_b;
`endif

    spi_slave #(.ADDR_W(8), .DATA_W(8)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss_a), .mosi(mosi), .miso(miso_a),
        .wr_valid(wr_valid_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .rd_valid(rd_valid_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .busy(busy_a)
`ifdef SPI_SLAVE_ERR_EN
        , .frame_err(frame_err_a), .err_count(err_count_a)
`endif
    );

    spi_slave #(.ADDR_W(16), .DATA_W(16)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss_b), .mosi(mosi), .miso(miso_b),
        .wr_valid(wr_valid_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .rd_valid(rd_valid_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .busy(busy_b)
`ifdef SPI_SLAVE_ERR_EN
        , .frame_err(frame_err_b), .err_count(err_count_b)
`endif
    );

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Observed events and model expectations, one set per instance.
    logic [31:0] wq_a[$], wq_b[$], rq_a[$], rq_b[$];
    logic [31:0] xw_a[$], xw_b[$], xr_a[$], xr_b[$];
    int fe_a = 0, fe_b = 0, xfe_a = 0, xfe_b = 0, xerr_a = 0, xerr_b = 0;

    always @(negedge clk) begin
        if (wr_valid_a) wq_a.push_back({16'(wr_addr_a), 16'(wr_data_a)});
        if (wr_valid_b) wq_b.push_back({16'(wr_addr_b), wr_data_b});
        if (rd_valid_a) rq_a.push_back(32'(rd_addr_a));
        if (rd_valid_b) rq_b.push_back(32'(rd_addr_b));
`ifdef SPI_SLAVE_ERR_EN
        if (frame_err_a) fe_a++;
        if (frame_err_b) fe_b++;
`endif
    end

    // Mode-0 master: 4 clk per sck half period, miso sampled as sck rises.
    task automatic spi_xfer(input bit sb, input logic [15:0] addr, input logic [15:0] data,
                            input int stop_at, input int rst_at, input int extra,
                            output logic [15:0] rx);
        int aw, total;
        logic [31:0] word;
        aw    = sb ? 16 : 8;
        total = 2 * aw;
        word  = sb ? {addr, data} : {16'h0, addr[7:0], data[7:0]};
        rx    = '0;
        if (sb) ss_b = 1'b0; else ss_a = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < total + extra; i++) begin
            if (i == stop_at) break;
            if (i == rst_at) begin
                reset_n = 1'b0;
                repeat (2) @(negedge clk);
                check("rst_miso", sb ? miso_b : miso_a, 0);
                check("rst_busy", sb ? busy_b : busy_a, 0);
                reset_n = 1'b1;
            end
            mosi = (i < total) ? word[total-1-i] : 1'($urandom);
            repeat (4) @(negedge clk);
            sck = 1'b1;
            if (i >= aw && i < total) rx = {rx[14:0], sb ? miso_b : miso_a};
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
        repeat (4) @(negedge clk);
        if (sb) ss_b = 1'b1; else ss_a = 1'b1;
        mosi = 1'b0;
    endtask

    task automatic expect_frame(input bit sb, input logic [15:0] addr, input logic [15:0] data,
                                input int stop_at);
        int aw;
        logic [15:0] am, dm;
        bit full, rd;
        aw   = sb ? 16 : 8;
        am   = sb ? 16'h7FFF : 16'h007F;
        dm   = sb ? 16'hFFFF : 16'h00FF;
        full = (stop_at < 0);
        rd   = sb ? addr[15] : addr[7];
        if (!rd && full) begin
            if (sb) xw_b.push_back({addr & am, data & dm});
            else    xw_a.push_back({addr & am, data & dm});
        end
        if (rd && (full || stop_at >= aw)) begin
            if (sb) xr_b.push_back(32'(addr & am));
            else    xr_a.push_back(32'(addr & am));
        end
        if (!full) begin
            if (sb) begin xfe_b++; if (xerr_b < 255) xerr_b++; end
            else    begin xfe_a++; if (xerr_a < 255) xerr_a++; end
        end
    endtask

    task automatic drain(input bit sb);
        logic [31:0] gw[$], gr[$], ew[$], er[$];
        repeat (6) @(negedge clk);
        if (sb) begin
            gw = wq_b; gr = rq_b; ew = xw_b; er = xr_b;
            wq_b.delete(); rq_b.delete(); xw_b.delete(); xr_b.delete();
        end else begin
            gw = wq_a; gr = rq_a; ew = xw_a; er = xr_a;
            wq_a.delete(); rq_a.delete(); xw_a.delete(); xr_a.delete();
        end
        check("wr_count", gw.size(), ew.size());
        for (int k = 0; k < ew.size() && k < gw.size(); k++) check("wr_addr_data", gw[k], ew[k]);
        check("rd_count", gr.size(), er.size());
        for (int k = 0; k < er.size() && k < gr.size(); k++) check("rd_addr", gr[k], er[k]);
`ifdef SPI_SLAVE_ERR_EN
        check("frame_err", sb ? fe_b : fe_a, sb ? xfe_b : xfe_a);
        check("err_count", sb ? err_count_b : err_count_a, sb ? xerr_b : xerr_a);
`endif
        check("busy_idle", sb ? busy_b : busy_a, 0);
        check("miso_idle", sb ? miso_b : miso_a, 0);
    endtask

    task automatic do_frame(input bit sb, input logic [15:0] addr, input logic [15:0] data,
                            input int stop_at, input int extra, input logic [15:0] rdw);
        logic [15:0] rx, dm;
        bit rd;
        dm = sb ? 16'hFFFF : 16'h00FF;
        rd = sb ? addr[15] : addr[7];
        if (sb) rd_data_b = rdw; else rd_data_a = rdw[7:0];
        expect_frame(sb, addr, data, stop_at);
        spi_xfer(sb, addr, data, stop_at, -1, extra, rx);
        if (rd && stop_at < 0) check("rd_shift", rx & dm, rdw & dm);
        drain(sb);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rx, a, d;
        int stop, total;
        bit sb;
        rd_data_a = '0;
        rd_data_b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy_a", busy_a, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_miso_a", miso_a, 0);
        check("rst_wr_valid", wr_valid_a, 0);
        check("rst_rd_valid", rd_valid_b, 0);
        check("rst_wr_data", wr_data_b, 0);
`ifdef SPI_SLAVE_ERR_EN
        check("rst_err_count", err_count_a, 0);
`endif
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        do_frame(0, 16'h0012, 16'h00A5, -1, 0, 16'h0000);
        do_frame(1, 16'h8034, 16'h0000, -1, 0, 16'hBEEF);
        do_frame(0, 16'h0033, 16'h0044, 11, 0, 16'h0000);

        expect_frame(0, 16'h0001, 16'h0011, -1);
        expect_frame(0, 16'h0002, 16'h0022, -1);
        spi_xfer(0, 16'h0001, 16'h0011, -1, -1, 0, rx);
        repeat (2) @(negedge clk);
        spi_xfer(0, 16'h0002, 16'h0022, -1, -1, 0, rx);
        drain(0);

        // Reset 20 bits into a 16/16 read: the read request has already gone out.
        rd_data_b = 16'h1234;
        xr_b.push_back(32'h0034);
        xerr_a = 0;
        xerr_b = 0;
        spi_xfer(1, 16'h8034, 16'h0000, -1, 20, 0, rx);
        drain(1);
        do_frame(1, 16'h0005, 16'h005A, -1, 0, 16'h0000);
        drain(0);

        for (int n = 0; n < 24; n++) begin
            sb    = 1'($urandom);
            a     = 16'($urandom);
            d     = 16'($urandom);
            total = sb ? 32 : 16;
            stop  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, total - 1)) : -1;
            do_frame(sb, a, d, stop, (stop < 0) ? int'($urandom_range(0, 2)) : 0, 16'($urandom));
        end

`ifdef SPI_SLAVE_ERR_EN
        for (int n = 0; n < 260; n++) begin
            expect_frame(0, 16'h0080, 16'h0000, 1);
            spi_xfer(0, 16'h0080, 16'h0000, 1, -1, 0, rx);
            repeat (3) @(negedge clk);
        end
        drain(0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
